conv5x5_pe_controller: RTL and testbench
========================================

Name: conv5x5_pe_controller

Overview:
- Sequencer for the 5x5 convolution MAC datapath, a chain of processing elements fed one (x, w) pair per cycle.
- Scans every valid output position of an IMG_H x IMG_W feature map and issues the 25 taps per position.
  - Read addresses go to the feature-map and weight memories.
  - Accumulator-clear and tap-valid strobes go to the PE chain.
- Flags each finished output after the datapath latency; start/busy/done handshake to the top-level controller.

Parameters:
- IMG_W, 8, input feature-map width in pixels (≥ K)
- IMG_H, 8, input feature-map height in pixels (≥ K)
- K, 5, kernel size (square); 25 taps per output
- LAT, 2, cycles from a tap's issue cycle to the PE-chain output reflecting that tap (≥ 1)
- XAW, 6, feature-map address width; must satisfy 2^XAW ≥ IMG_W*IMG_H
- WAW, 5, weight address width; must satisfy 2^WAW ≥ K*K
- OAW, 4, output address width; must satisfy 2^OAW ≥ OW*OH, where OW = IMG_W-K+1 and OH = IMG_H-K+1

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous reset, active-high
- i_start  in  1  begin one full-frame convolution; sampled only in IDLE
- i_abort  in  1  cancel the current frame
- o_busy  out  1  high from the first issue cycle through the o_done cycle
- o_done  out  1  one-cycle pulse when the frame is complete
- o_x_addr  out  XAW  feature-map read address
- o_w_addr  out  WAW  weight read address
- o_tap_valid  out  1  o_x_addr / o_w_addr are a live tap this cycle
- o_psum_clr  out  1  first tap of an output position; PE chain restarts accumulation
- o_out_valid  out  1  PE-chain output is a finished convolution result this cycle
- o_out_addr  out  OAW  output-map address of that result, = orow*OW + ocol

Behaviour:
- Reset:
  - Synchronous i_rst forces state IDLE and zeroes all counters and the delay line.
  - Every output reads 0 in the cycle after i_rst is sampled, including mid-frame.
  - A reset mid-frame produces no o_done and no further o_out_valid.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: i_start=1 → ISSUE. Counters orow=ocol=kr=kc=0.
  - ISSUE: one tap per cycle, no bubbles; tap counter advances every cycle.
    - Tap order is kc fastest, then kr, then ocol, then orow.
    - After tap (OH-1, OW-1, K-1, K-1) → DRAIN.
  - DRAIN: issues nothing; waits until the last result has emerged (LAT cycles) → DONE.
  - DONE: o_done=1 for exactly one cycle → IDLE.
- Registered outputs in ISSUE:
  - o_tap_valid = 1
  - o_x_addr = (orow+kr)*IMG_W + (ocol+kc)
  - o_w_addr = kr*K + kc
  - o_psum_clr = 1 iff kr=0 and kc=0
  - Outside ISSUE: o_tap_valid = o_psum_clr = 0, and both addresses are held at 0.
- Output flagging:
  - The last tap of a position (kr=kc=K-1) pushes {1, orow*OW+ocol} into a LAT-deep delay line.
  - o_out_valid / o_out_addr are that entry exactly LAT cycles later.
  - Back-to-back positions therefore produce o_out_valid pulses spaced K*K cycles apart.
- Address arithmetic:
  - Incremental adders only; no multipliers. Row base advances by IMG_W per kr, plus an orow base.
  - Results are unsigned and never exceed IMG_W*IMG_H-1, so no wrap occurs.
- Handshake and timing:
  - Start is accepted at cycle c; first tap at c+1.
  - Last tap at c+OW*OH*K*K; last o_out_valid at c+OW*OH*K*K+LAT; o_done one cycle after that.
  - o_busy covers c+1 through the o_done cycle.
- Boundary conditions:
  - i_start outside IDLE is ignored, including i_start coincident with the DONE cycle.
  - i_abort in ISSUE or DRAIN → IDLE next cycle: delay line flushed, no o_out_valid or o_done afterwards.
  - i_abort in IDLE or DONE is ignored.
  - i_abort together with i_start in IDLE → stay in IDLE.
  - i_rst has priority over everything.
  - IMG_W=IMG_H=K gives a single output position (OW=OH=1); required to work.

Decomposition:
- Shared package conv5x5_pkg holds:
  - K
  - the state encoding (IDLE=0, ISSUE=1, DRAIN=2, DONE=3)
  - functions for OW/OH and the tap count K*K.
- One sub-module, valid_delay_line:
  - parameterised LAT-stage shift register of {valid, addr[OAW-1:0]} with synchronous flush on abort/reset;
  - reused later for other datapath-latency alignment.

Test Plan:
1. Reset/idle: i_rst high 3 cycles, then low with i_start=0 for 10 cycles → all outputs 0 throughout; state stays IDLE.
2. Full frame, defaults (16 positions, 400 taps): start accepted at cycle 0.
   - Cycle 1: x_addr=0, w_addr=0, psum_clr=1.
   - Cycle 25: x_addr=36, w_addr=24.
   - First out_valid at cycle 27 with out_addr=0; last out_valid at cycle 402 with out_addr=15.
   - o_done at cycle 403; exactly 16 out_valid pulses; busy high from cycle 1 to 403.
3. Position stepping: second position's first tap (cycle 26) → x_addr=1, psum_clr=1; fifth position's first tap (cycle 101) → x_addr=8, out_addr later 4.
4. Abort mid-frame: i_abort at cycle 60 → cycle 61 all outputs 0, state IDLE.
   - No out_valid after cycle 61 and no o_done. Earlier out_valid pulses at cycles 27 and 52 are unaffected.
   - A new start is then accepted normally.
5. Start while busy and reset mid-DRAIN:
   - i_start pulses at cycles 5 and 200 → no effect on the address sequence.
   - i_rst at cycle 401 → no o_out_valid at 402, no o_done.
6. Minimum map IMG_W=IMG_H=5, LAT=1: 25 taps, x_addr 0..24 in order.
   - out_valid at cycle 26 with out_addr=0; o_done at cycle 27.

Source files
------------

// File: rtl/conv5x5_pkg.sv
// conv5x5_pkg: shared kernel size, sequencer state encoding and geometry helpers
package conv5x5_pkg;
  localparam int K = 5;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_e;
  function automatic int out_dim(input int img, input int k);
    return img - k + 1;
  endfunction
  function automatic int tap_count(input int k);
    return k * k;
  endfunction
endpackage

// File: rtl/valid_delay_line.sv
// valid_delay_line: LAT-stage {valid, addr} shift register with synchronous flush
module valid_delay_line #(
  parameter int LAT = 2,
  parameter int AW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          valid_i,
  input  logic [AW-1:0] addr_i,
  output logic          valid_o,
  output logic [AW-1:0] addr_o
);
  logic          v_q [LAT];
  logic [AW-1:0] a_q [LAT];
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      for (int i = 0; i < LAT; i++) begin
        v_q[i] <= 1'b0;
        a_q[i] <= '0;
      end
    end else begin
      v_q[0] <= valid_i;
      a_q[0] <= addr_i;
      for (int i = 1; i < LAT; i++) begin
        v_q[i] <= v_q[i-1];
        a_q[i] <= a_q[i-1];
      end
    end
  end
  assign valid_o = v_q[LAT-1];
  assign addr_o  = a_q[LAT-1];
endmodule

// File: rtl/conv5x5_pe_controller.sv
// conv5x5_pe_controller: scans all valid output positions, issuing K*K taps each,
// and flags finished results after the PE-chain latency
module conv5x5_pe_controller #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int K     = conv5x5_pkg::K,
  parameter int LAT   = 2,
  parameter int XAW   = 6,
  parameter int WAW   = 5,
  parameter int OAW   = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_abort,
  output logic           o_busy,
  output logic           o_done,
  output logic [XAW-1:0] o_x_addr,
  output logic [WAW-1:0] o_w_addr,
  output logic           o_tap_valid,
  output logic           o_psum_clr,
  output logic           o_out_valid,
  output logic [OAW-1:0] o_out_addr
);
  import conv5x5_pkg::*;
  localparam int OW = out_dim(IMG_W, K);
  localparam int OH = out_dim(IMG_H, K);
  localparam int NT = tap_count(K);
  localparam int CW = $clog2(IMG_W + IMG_H);
  localparam int DW = $clog2(LAT + 1);
  state_e state_q, state_d;
  logic [CW-1:0] kc_q, kc_d, ocol_q, ocol_d, orow_q, orow_d;
  logic [XAW-1:0] x_q, x_d, row_q, row_d, pos_q, pos_d, nxt_pos, nxt_row;
  logic [WAW-1:0] w_q, w_d;
  logic [OAW-1:0] oaddr_q, oaddr_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic kc_last, tap_last, col_last, row_last, frame_last, run, push, flush;
  assign kc_last    = kc_q == CW'(K - 1);
  assign tap_last   = w_q == WAW'(NT - 1);
  assign col_last   = ocol_q == CW'(OW - 1);
  assign row_last   = orow_q == CW'(OH - 1);
  assign frame_last = tap_last && col_last && row_last;
  // pos tracks the window's top-left pixel; stepping past the last column lands K pixels on
  assign nxt_pos = col_last ? pos_q + XAW'(K) : pos_q + XAW'(1);
  assign nxt_row = tap_last ? nxt_pos : row_q + XAW'(IMG_W);
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = (i_start && !i_abort) ? ISSUE : IDLE;
      ISSUE:   state_d = i_abort ? IDLE : frame_last ? DRAIN : ISSUE;
      DRAIN:   state_d = i_abort ? IDLE : (dcnt_q == DW'(LAT - 1)) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    run     = state_q == ISSUE && state_d == ISSUE;
    kc_d    = run ? (kc_last ? '0 : kc_q + CW'(1)) : '0;
    w_d     = run ? (tap_last ? '0 : w_q + WAW'(1)) : '0;
    x_d     = run ? (kc_last ? nxt_row : x_q + XAW'(1)) : '0;
    row_d   = run ? (kc_last ? nxt_row : row_q) : '0;
    pos_d   = run ? (tap_last ? nxt_pos : pos_q) : '0;
    ocol_d  = run ? (tap_last ? (col_last ? '0 : ocol_q + CW'(1)) : ocol_q) : '0;
    orow_d  = run ? ((tap_last && col_last) ? orow_q + CW'(1) : orow_q) : '0;
    oaddr_d = run ? (tap_last ? oaddr_q + OAW'(1) : oaddr_q) : '0;
    dcnt_d  = (state_q == DRAIN && state_d == DRAIN) ? dcnt_q + DW'(1) : '0;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      kc_q    <= '0;
      w_q     <= '0;
      x_q     <= '0;
      row_q   <= '0;
      pos_q   <= '0;
      ocol_q  <= '0;
      orow_q  <= '0;
      oaddr_q <= '0;
      dcnt_q  <= '0;
    end else begin
      kc_q    <= kc_d;
      w_q     <= w_d;
      x_q     <= x_d;
      row_q   <= row_d;
      pos_q   <= pos_d;
      ocol_q  <= ocol_d;
      orow_q  <= orow_d;
      oaddr_q <= oaddr_d;
      dcnt_q  <= dcnt_d;
    end
  end
  always_comb begin
    o_busy      = state_q != IDLE;
    o_done      = state_q == DONE;
    o_tap_valid = state_q == ISSUE;
    o_psum_clr  = state_q == ISSUE && w_q == '0;
    push        = state_q == ISSUE && tap_last;
    flush       = i_abort && (state_q == ISSUE || state_q == DRAIN);
  end
  assign o_x_addr = x_q;
  assign o_w_addr = w_q;
  valid_delay_line #(.LAT(LAT), .AW(OAW)) u_dly (
    .clk     (i_clk),
    .rst     (i_rst),
    .flush_i (flush),
    .valid_i (push),
    .addr_i  (push ? oaddr_q : '0),
    .valid_o (o_out_valid),
    .addr_o  (o_out_addr)
  );
endmodule

// File: tb/tb_conv5x5_pe_controller.sv
// tb_conv5x5_pe_controller: directed vectors for the default 8x8 map and the minimum 5x5 map
module tb_conv5x5_pe_controller;
  logic clk = 1'b0, rst = 1'b1;
  logic start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
  logic busy0, done0, tv0, pc0, ov0, busy1, done1, tv1, pc1, ov1;
  logic [5:0] x0, x1;
  logic [4:0] w0, w1;
  logic [3:0] oa0, oa1;
  logic [19:0] g0, g1;
  int passed = 0, total = 0;
  typedef struct {
    int          cyc;
    logic [19:0] e;
  } vec_t;
  vec_t tbl [15];
  always #5 clk = ~clk;
  conv5x5_pe_controller dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .i_abort(abort0), .o_busy(busy0), .o_done(done0),
    .o_x_addr(x0), .o_w_addr(w0), .o_tap_valid(tv0), .o_psum_clr(pc0), .o_out_valid(ov0), .o_out_addr(oa0)
  );
  conv5x5_pe_controller #(.IMG_W(5), .IMG_H(5), .LAT(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_abort(abort1), .o_busy(busy1), .o_done(done1),
    .o_x_addr(x1), .o_w_addr(w1), .o_tap_valid(tv1), .o_psum_clr(pc1), .o_out_valid(ov1), .o_out_addr(oa1)
  );
  assign g0 = {x0, w0, tv0, pc0, ov0, oa0, busy0, done0};
  assign g1 = {x1, w1, tv1, pc1, ov1, oa1, busy1, done1};
  function automatic logic [19:0] pk(int x, int w, int tv, int pc, int ov, int oa, int busy, int done);
    return {6'(x), 5'(w), 1'(tv), 1'(pc), 1'(ov), 4'(oa), 1'(busy), 1'(done)};
  endfunction
  function automatic vec_t mk(int c, logic [19:0] e);
    vec_t v;
    v.cyc = c;
    v.e = e;
    return v;
  endfunction
  // independent model of the default 8x8/LAT=2 frame; everything reads 0 from cycle cut on
  function automatic logic [19:0] exp_def(int c, int cut);
    int t, tap, p, x, w, tv, pc, ov, oa;
    if (c < 1 || c >= cut || c > 403) return '0;
    x = 0; w = 0; tv = 0; pc = 0; ov = 0; oa = 0;
    if (c <= 400) begin
      t = c - 1;
      p = t / 25;
      tap = t % 25;
      x = ((p / 4) + tap / 5) * 8 + (p % 4) + tap % 5;
      w = tap;
      tv = 1;
      pc = (tap == 0) ? 1 : 0;
    end
    if (c >= 27 && c <= 402 && (c - 2) % 25 == 0) begin
      ov = 1;
      oa = (c - 2) / 25 - 1;
    end
    return pk(x, w, tv, pc, ov, oa, 1, (c == 403) ? 1 : 0);
  endfunction
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_default(input string nm, input int abort_at, input int rst_at, input int s1, input int s2,
                             input int exp_ov, input int exp_done, input bit use_tbl);
    int cut, mism, bad, ovn, dn, ti;
    logic [19:0] bg, be, e;
    cut = 100000; mism = 0; bad = -1; ovn = 0; dn = 0; ti = 0; bg = '0; be = '0;
    if (abort_at > 0) cut = abort_at + 1;
    if (rst_at > 0) cut = rst_at + 1;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int c = 1; c <= 410; c++) begin
      e = exp_def(c, cut);
      if (g0 !== e) begin
        mism++;
        if (bad < 0) begin
          bad = c; bg = g0; be = e;
        end
      end
      ovn += int'(ov0);
      dn += int'(done0);
      if (use_tbl && ti < 15 && tbl[ti].cyc == c) begin
        check($sformatf("%s_c%0d", nm, c), 64'(g0), 64'(tbl[ti].e));
        ti++;
      end
      start0 = (c == s1 || c == s2);
      abort0 = (c == abort_at);
      rst = (c == rst_at);
      step();
    end
    start0 = 1'b0; abort0 = 1'b0; rst = 1'b0;
    if (mism != 0) $display("FAIL %s_model: %0d bad cycles, first c%0d got %0h expected %0h", nm, mism, bad, bg, be);
    check({nm, "_model_mismatches"}, 64'(mism), 64'd0);
    check({nm, "_out_valid_count"}, 64'(ovn), 64'(exp_ov));
    check({nm, "_done_count"}, 64'(dn), 64'(exp_done));
    if (use_tbl) check({nm, "_tbl_reached"}, 64'(ti), 64'd15);
  endtask
  initial begin
    int mism;
    logic [19:0] e;
    tbl[0]  = mk(1,   pk(0, 0, 1, 1, 0, 0, 1, 0));
    tbl[1]  = mk(2,   pk(1, 1, 1, 0, 0, 0, 1, 0));
    tbl[2]  = mk(6,   pk(8, 5, 1, 0, 0, 0, 1, 0));
    tbl[3]  = mk(25,  pk(36, 24, 1, 0, 0, 0, 1, 0));
    tbl[4]  = mk(26,  pk(1, 0, 1, 1, 0, 0, 1, 0));
    tbl[5]  = mk(27,  pk(2, 1, 1, 0, 1, 0, 1, 0));
    tbl[6]  = mk(52,  pk(3, 1, 1, 0, 1, 1, 1, 0));
    tbl[7]  = mk(101, pk(8, 0, 1, 1, 0, 0, 1, 0));
    tbl[8]  = mk(102, pk(9, 1, 1, 0, 1, 3, 1, 0));
    tbl[9]  = mk(127, pk(10, 1, 1, 0, 1, 4, 1, 0));
    tbl[10] = mk(400, pk(63, 24, 1, 0, 0, 0, 1, 0));
    tbl[11] = mk(401, pk(0, 0, 0, 0, 0, 0, 1, 0));
    tbl[12] = mk(402, pk(0, 0, 0, 0, 1, 15, 1, 0));
    tbl[13] = mk(403, pk(0, 0, 0, 0, 0, 0, 1, 1));
    tbl[14] = mk(404, pk(0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 13; i++) begin
      step();
      check($sformatf("idle_c%0d", i), {g0, g1}, 64'd0);
      if (i == 2) rst = 1'b0;
    end
    run_default("frame", 0, 0, 403, -1, 16, 1, 1'b1);
    run_default("abort", 60, 0, -1, -1, 2, 0, 1'b0);
    run_default("rst_drain", 0, 401, 5, 200, 15, 0, 1'b0);
    start0 = 1'b1;
    abort0 = 1'b1;
    step();
    start0 = 1'b0;
    abort0 = 1'b0;
    check("start_abort_idle_c1", 64'(g0), 64'd0);
    step();
    check("start_abort_idle_c2", 64'(g0), 64'd0);
    mism = 0;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      e = pk((c <= 25) ? c - 1 : 0, (c <= 25) ? c - 1 : 0, (c <= 25) ? 1 : 0, (c == 1) ? 1 : 0,
             (c == 26) ? 1 : 0, 0, (c <= 27) ? 1 : 0, (c == 27) ? 1 : 0);
      if (g1 !== e) begin
        mism++;
        $display("FAIL small_c%0d: got %0h expected %0h", c, g1, e);
      end
      if (c == 25) check("small_last_tap_x", 64'(x1), 64'd24);
      if (c == 26) check("small_out_valid", 64'({ov1, oa1}), 64'({1'b1, 4'd0}));
      if (c == 27) check("small_done", 64'({done1, busy1}), 64'b11);
      step();
    end
    check("small_model_mismatches", 64'(mism), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
